// File: rtl/mpram.sv
// Multi-port front end for one single-port RAM. A rotating pointer picks at most
// one requester per clock, and the selected port completes one cycle later.
module mpram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int PORTS     = 2,
  parameter int SKIP_IDLE = 0,
  localparam int PTR_W    = $clog2(PORTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PORTS-1:0]          req,
  input  logic [PORTS-1:0]          we,
  input  logic [PORTS*ADDR_W-1:0]   addr,
  input  logic [PORTS*DATA_W-1:0]   wdata,
  output logic [PORTS-1:0]          ack,
  output logic [PORTS*DATA_W-1:0]   rdata,
  output logic [PTR_W-1:0]          dbg_ptr,
  output logic [PORTS-1:0]          dbg_pending
);

  // Handshake: a port holds req/we/addr/wdata stable until its issue edge. ack
  // pulses for the single cycle after the completion edge (issue edge + 1), with
  // rdata for that port already updated. req still high while ack is high is
  // taken as a fresh request.

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PORTS-1:0]  pending;
  logic [PORTS-1:0]  eligible;
  logic              grant_valid;
  logic [PTR_W-1:0]  grant_idx;
  logic              fly_valid;
  logic [PTR_W-1:0]  fly_idx;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  always_comb begin
    eligible    = req & ~pending;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (SKIP_IDLE == 0) begin
      if (eligible[ptr]) begin
        grant_valid = 1'b1;
        grant_idx   = ptr;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        int c;
        c = int'(ptr) + i;
        if (c >= PORTS) c = c - PORTS;
        if (!grant_valid && eligible[PTR_W'(c)]) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(c);
        end
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (SKIP_IDLE == 0) begin
      ptr_next = (ptr == PTR_W'(PORTS - 1)) ? '0 : ptr + PTR_W'(1);
    end else if (grant_valid) begin
      ptr_next = (grant_idx == PTR_W'(PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  assign sel_addr  = addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_we    = we[grant_idx];

  // RAM has no reset so its contents survive; reset only blocks new accesses.
  always_ff @(posedge clk) begin
    if (!reset && grant_valid) begin
      ram_q <= mem[sel_addr];
      if (sel_we) mem[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      pending   <= '0;
      ack       <= '0;
      rdata     <= '0;
      fly_valid <= 1'b0;
      fly_idx   <= '0;
    end else begin
      ptr       <= ptr_next;
      ack       <= '0;
      fly_valid <= grant_valid;
      fly_idx   <= grant_idx;
      // The completing port is still pending here, so it can never equal grant_idx.
      if (fly_valid) begin
        ack[fly_idx]                             <= 1'b1;
        rdata[int'(fly_idx)*DATA_W +: DATA_W]    <= ram_q;
        pending[fly_idx]                         <= 1'b0;
      end
      if (grant_valid) pending[grant_idx] <= 1'b1;
    end
  end

  assign dbg_ptr     = ptr;
  assign dbg_pending = pending;

endmodule

// File: tb/tb_mpram.sv
// Bench for mpram with PORTS=3, DATA_W=8, ADDR_W=4: one instance per SKIP_IDLE
// mode, each with its own stimulus bus and a per-edge behavioural reference model.
module tb_mpram;

  localparam int NP = 3;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [NP-1:0]    req_i   [2];
  logic [NP-1:0]    we_i    [2];
  logic [NP*AW-1:0] addr_i  [2];
  logic [NP*DW-1:0] wdata_i [2];
  logic [NP-1:0]    ack_o   [2];
  logic [NP*DW-1:0] rdata_o [2];
  logic [1:0]       ptr_o   [2];
  logic [NP-1:0]    pend_o  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpram #(.DATA_W(DW), .ADDR_W(AW), .PORTS(NP), .SKIP_IDLE(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_i[0]), .we(we_i[0]), .addr(addr_i[0]),
    .wdata(wdata_i[0]), .ack(ack_o[0]), .rdata(rdata_o[0]), .dbg_ptr(ptr_o[0]),
    .dbg_pending(pend_o[0]));

  mpram #(.DATA_W(DW), .ADDR_W(AW), .PORTS(NP), .SKIP_IDLE(1)) dut1 (
    .clk(clk), .reset(reset), .req(req_i[1]), .we(we_i[1]), .addr(addr_i[1]),
    .wdata(wdata_i[1]), .ack(ack_o[1]), .rdata(rdata_o[1]), .dbg_ptr(ptr_o[1]),
    .dbg_pending(pend_o[1]));

  // Reference model: arbitration rules applied directly on arrays, per instance.
  int          m_ptr  [2];
  bit [NP-1:0] m_pend [2];
  bit [NP-1:0] m_ack  [2];
  bit          m_fv   [2];
  int          m_fi   [2];
  bit [DW-1:0] m_q    [2];
  bit          m_qk   [2];
  bit [DW-1:0] m_mem  [2][16];
  bit          m_mk   [2][16];
  bit [DW-1:0] m_rd   [2][NP];
  bit          m_rk   [2][NP];

  always @(posedge clk) begin
    int g;
    int c;
    int a;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ptr[k]  = 0;
        m_pend[k] = '0;
        m_ack[k]  = '0;
        m_fv[k]   = 1'b0;
        for (int p = 0; p < NP; p++) begin
          m_rd[k][p] = '0;
          m_rk[k][p] = 1'b1;
        end
      end else begin
        g = -1;
        for (int i = 0; i < NP; i++) begin
          c = (m_ptr[k] + i) % NP;
          if (g < 0 && (k == 1 || i == 0) && req_i[k][c] && !m_pend[k][c]) g = c;
        end
        m_ack[k] = '0;
        if (m_fv[k]) begin
          m_ack[k][m_fi[k]]  = 1'b1;
          m_rd[k][m_fi[k]]   = m_q[k];
          m_rk[k][m_fi[k]]   = m_qk[k];
          m_pend[k][m_fi[k]] = 1'b0;
        end
        m_fv[k] = (g >= 0);
        if (g >= 0) begin
          a = int'(addr_i[k][g*AW +: AW]);
          m_q[k]  = m_mem[k][a];
          m_qk[k] = m_mk[k][a];
          if (we_i[k][g]) begin
            m_mem[k][a] = wdata_i[k][g*DW +: DW];
            m_mk[k][a]  = 1'b1;
          end
          m_pend[k][g] = 1'b1;
          m_fi[k]      = g;
        end
        if (k == 1) m_ptr[k] = (g >= 0) ? (g + 1) % NP : m_ptr[k];
        else        m_ptr[k] = (m_ptr[k] + 1) % NP;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ack[dut%0d]", k), 32'(ack_o[k]), 32'(m_ack[k]));
      chk($sformatf("ptr[dut%0d]", k), 32'(ptr_o[k]), 32'(m_ptr[k]));
      chk($sformatf("pending[dut%0d]", k), 32'(pend_o[k]), 32'(m_pend[k]));
      chk($sformatf("ack_onehot[dut%0d]", k), 32'($countones(ack_o[k]) <= 1), 32'd1);
      for (int p = 0; p < NP; p++)
        if (m_rk[k][p])
          chk($sformatf("rdata[dut%0d][%0d]", k, p), 32'(rdata_o[k][p*DW +: DW]),
              32'(m_rd[k][p]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_access(input int k, input int p, input bit w, input int a,
                           input logic [DW-1:0] d, output logic [DW-1:0] got);
    bit seen;
    seen = 1'b0;
    req_i[k][p]          = 1'b1;
    we_i[k][p]           = w;
    addr_i[k][p*AW +: AW]   = AW'(a);
    wdata_i[k][p*DW +: DW]  = d;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (ack_o[k][p]) seen = 1'b1;
    end
    req_i[k][p] = 1'b0;
    chk($sformatf("ack_timeout[dut%0d][%0d]", k, p), 32'(seen), 32'd1);
    got = rdata_o[k][p*DW +: DW];
  endtask

  initial begin
    logic [DW-1:0] got;
    logic [DW-1:0] keep0;
    int p0;
    for (int k = 0; k < 2; k++) begin
      req_i[k] = '0; we_i[k] = '0; addr_i[k] = '0; wdata_i[k] = '0;
    end

    // Reset, then an idle stretch.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ptr0", 32'(ptr_o[0]), 32'((i + 1) % 3));
      chk("idle_ptr1", 32'(ptr_o[1]), 32'd0);
      for (int k = 0; k < 2; k++) begin
        chk("idle_ack", 32'(ack_o[k]), 32'd0);
        chk("idle_rdata", 32'(rdata_o[k]), 32'd0);
      end
    end

    // Fill every word so later reads have known contents.
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) do_access(k, 0, 1'b1, a, DW'(a * 7 + 1), got);

    for (int k = 0; k < 2; k++) begin
      // Write on port 1, read back on port 2; port 0 and 1 data undisturbed.
      keep0 = rdata_o[k][0 +: DW];
      do_access(k, 1, 1'b1, 3, 8'hA5, got);
      chk("wr_old_contents", 32'(got), 32'h16);
      do_access(k, 2, 1'b0, 3, 8'h00, got);
      chk("rd_after_wr", 32'(got), 32'hA5);
      chk("rdata0_kept", 32'(rdata_o[k][0 +: DW]), 32'(keep0));
      chk("rdata1_kept", 32'(rdata_o[k][DW +: DW]), 32'h16);
      // Read-first behaviour on an overwrite.
      do_access(k, 1, 1'b1, 7, 8'h11, got);
      do_access(k, 0, 1'b1, 7, 8'h22, got);
      chk("read_first", 32'(got), 32'h11);
      do_access(k, 2, 1'b0, 7, 8'h00, got);
      chk("rd_new_value", 32'(got), 32'h22);
    end

    // Work-conserving mode, only port 2 requesting.
    req_i[1] = 3'b100; we_i[1] = '0; addr_i[1] = {4'h7, 8'h00};
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("solo_ack2", 32'(ack_o[1][2]), 32'(i % 2));
      chk("solo_ptr", 32'(ptr_o[1]), 32'd0);
    end
    req_i[1] = '0;
    repeat (2) tick();

    // Fixed rotation, every port requesting.
    p0 = m_ptr[0];
    req_i[0] = 3'b111; we_i[0] = '0;
    addr_i[0] = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rot_ack", 32'(ack_o[0]), (i == 0) ? 32'd0 : 32'(1 << ((p0 + i - 1) % 3)));
    end
    req_i[0] = '0;
    repeat (2) tick();

    // Reset landing on the completion edge of a write.
    for (int k = 0; k < 2; k++) begin
      bit issued;
      issued = 1'b0;
      req_i[k][0] = 1'b1; we_i[k][0] = 1'b1; addr_i[k][0 +: AW] = 4'h1;
      wdata_i[k][0 +: DW] = 8'h5A;
      for (int n = 0; n < 10 && !issued; n++) begin
        tick();
        if (m_pend[k][0]) issued = 1'b1;
      end
      chk("issue_seen", 32'(issued), 32'd1);
      req_i[k] = '0;
      reset = 1'b1;
      tick();
      chk("rst_no_ack", 32'(ack_o[k]), 32'd0);
      chk("rst_rdata0", 32'(rdata_o[k][0 +: DW]), 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_ack", 32'(ack_o[k]), 32'd0);
      chk("post_rst_rdata0", 32'(rdata_o[k][0 +: DW]), 32'd0);
      do_access(k, 0, 1'b0, 1, 8'h00, got);
      chk("write_persists", 32'(got), 32'h5A);
    end

    // Random traffic on both instances, checked against the model each cycle.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 2; k++) begin
        req_i[k]   = 3'($urandom_range(0, 7));
        we_i[k]    = 3'($urandom_range(0, 7));
        addr_i[k]  = 12'($urandom_range(0, 4095));
        wdata_i[k] = 24'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) req_i[k] = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
